bus_transfer_sequencer: RTL and testbench
=========================================

Name: bus_transfer_sequencer

Overview:
Upstream control stage for the shared 8-bit data bus. It accepts register-to-register transfer requests (source index, destination index) over a valid/ready handshake. For each accepted request it drives a one-hot output-enable vector, one bit per tri-state bus driver instance, then pulses a one-hot load strobe to the destination. Break-before-make sequencing guarantees at most one driver enables the bus in any cycle, and no driver is enabled during the cycle in which enables change owner.

Parameters:
N_SRC, 4, number of bus sources (tri-state drivers); each owns one oe bit.
N_DST, 4, number of bus destinations; each owns one ld bit.
WIDTH, 8, bus data width.
SETTLE_CYCLES, 1, cycles the source drives the bus before ld is pulsed; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  transfer request present.
req_ready  output  1  sequencer can accept a request this cycle.
req_src  input  $clog2(N_SRC)  source index.
req_dst  input  $clog2(N_DST)  destination index.
bus_in  input  WIDTH  resolved bus value, observed for capture.
oe  output  N_SRC  one-hot/zero output enables to tri-state drivers.
ld  output  N_DST  one-hot/zero single-cycle load strobe to destinations.
last_data  output  WIDTH  bus value captured on the last completed transfer.
done  output  1  single-cycle pulse when a transfer completes.
err  output  1  single-cycle pulse when a request is rejected.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, while rst_n=0): state=IDLE, oe=0, ld=0, done=0, err=0, busy=0, last_data=0, req_ready=0. req_ready goes high one cycle after rst_n deasserts.
- Reset mid-transfer: oe and ld clear immediately, without waiting for a clock edge. The in-flight transfer is dropped and no done pulse is produced.
- States: IDLE, DRIVE, LOAD, RELEASE.
- IDLE:
  - req_ready=1.
  - On req_valid, validate the request. It is rejected if req_src>=N_SRC, req_dst>=N_DST, or the indices name the same physical register (src==dst, under the index-equality convention).
  - Rejected request: err=1 for the next cycle; stay in IDLE; oe stays 0.
  - Accepted request: latch src and dst, load settle counter=SETTLE_CYCLES, go to DRIVE.
- DRIVE:
  - oe[src]=1; counter decrements each cycle.
  - When the counter reaches 1, go to LOAD.
  - DRIVE lasts exactly SETTLE_CYCLES cycles.
- LOAD (one cycle):
  - oe[src] is held at 1 so bus data stays stable through the load edge.
  - ld[dst]=1.
  - last_data<=bus_in on the clock edge that leaves LOAD.
  - Go to RELEASE.
- RELEASE (one cycle):
  - oe=0, ld=0, done=1.
  - Go to IDLE.
  - req_ready is 0 in RELEASE, so the next transfer's oe rises at the earliest two cycles after the previous oe falls. This is the break-before-make gap.
- Handshake: a request is accepted only on a cycle where req_valid&&req_ready. While busy, req_ready=0 and inputs are ignored. The requester holds req_src/req_dst stable until acceptance.
- Latency, accept edge to done pulse: SETTLE_CYCLES+2 cycles. Minimum throughput: one transfer per SETTLE_CYCLES+3 cycles.
- Invariants: popcount(oe)<=1 and popcount(ld)<=1 every cycle; ld is never high without oe high.
- All outputs are registered; no combinational path from req_* to oe/ld.

Decomposition:
- Package bus_seq_pkg holds:
  - state enum (IDLE, DRIVE, LOAD, RELEASE);
  - function idx_w(n) returning $clog2 with a minimum of 1;
  - constant SETTLE_W=4.
- Sub-module onehot_decoder (parameters N, W; inputs en and idx; output N-bit one-hot, all-zero when en=0 or idx>=N). It is instantiated twice: once for oe, once for ld.

Test Plan:
- Basic transfer, SETTLE_CYCLES=1, req src=2 dst=0, bus_in=8'h0A -> oe=4'b0100 for 2 cycles, ld=4'b0001 in the 2nd of them, then done pulse, last_data=8'h0A; done 3 cycles after accept.
- Back-to-back, req_valid held with src=1 dst=3 then src=3 dst=1 -> second request accepted only after RELEASE; a cycle with oe=0 separates oe=4'b0010 and oe=4'b1000; done pulses twice.
- Rejection, src=2 dst=2, then N_SRC=3 with src=3 -> err pulses once per request, oe/ld stay 0, busy stays 0, last_data unchanged.
- SETTLE_CYCLES=5, src=0 dst=1, bus_in=8'h50 -> oe[0] high for 6 cycles, ld[1] only in the 6th, last_data=8'h50, done 7 cycles after accept.
- Async reset asserted during DRIVE (between clock edges) -> oe=0 immediately; no done; after release req_ready=1 next cycle and a fresh transfer src=1 dst=2 (bus_in=8'h1E) completes normally.
- Random stress, 1000 random requests with random req_valid gaps -> assertions popcount(oe)<=1, popcount(ld)<=1, ld implies oe, and the done count equals the accepted-request count.

Source files
------------

// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
// Holds the sequencer state encoding, the settle counter width and index sizing.
package bus_seq_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Index width for n items; a single item still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake and bus-control signals of the transfer sequencer.
// The master side issues requests and supplies bus_in; the slave side is the sequencer.
interface bus_transfer_sequencer_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned N_DST = 4,
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned SRC_W = bus_seq_pkg::idx_w(N_SRC);
  localparam int unsigned DST_W = bus_seq_pkg::idx_w(N_DST);

  logic             req_valid;
  logic             req_ready;
  logic [SRC_W-1:0] req_src;
  logic [DST_W-1:0] req_dst;
  logic [WIDTH-1:0] bus_in;
  logic [N_SRC-1:0] oe;
  logic [N_DST-1:0] ld;
  logic [WIDTH-1:0] last_data;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_src, req_dst, bus_in,
    input  req_ready, oe, ld, last_data, done, err, busy
  );

  modport slave (
    input  req_valid, req_src, req_dst, bus_in,
    output req_ready, oe, ld, last_data, done, err, busy
  );

endinterface

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with enable.
// Produces all zeros when disabled or when the index is outside 0..N-1.
module onehot_decoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  assign onehot = (en && (32'(idx) < N)) ? (N'(1) << idx) : '0;

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Break-before-make sequencer for register-to-register transfers on the shared bus.
// Drives one-hot output enables for the source, then a one-cycle load strobe to the destination.
module bus_transfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned N_DST         = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  bus_transfer_sequencer_if.slave bus
);

  localparam int unsigned SRC_W = idx_w(N_SRC);
  localparam int unsigned DST_W = idx_w(N_DST);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [DST_W-1:0]    dst_q, dst_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0]    oe_q, oe_d;
  logic [N_DST-1:0]    ld_q, ld_d;
  logic [WIDTH-1:0]    last_data_q, last_data_d;
  logic                req_ready_q, req_ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                accept_c;
  logic                bad_req_c;
  logic                drive_en_c;
  logic                load_en_c;

  // Out-of-range indices and self-transfers are rejected.
  assign bad_req_c = (32'(bus.req_src) >= N_SRC) ||
                     (32'(bus.req_dst) >= N_DST) ||
                     (32'(bus.req_src) == 32'(bus.req_dst));

  assign accept_c = (state_q == IDLE) && req_ready_q && bus.req_valid;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (bad_req_c) begin
            err_d = 1'b1;
          end else begin
            src_d   = bus.req_src;
            dst_d   = bus.req_dst;
            cnt_d   = SETTLE_W'(SETTLE_CYCLES);
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q <= SETTLE_W'(1)) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      LOAD: begin
        last_data_d = bus.bus_in;
        state_d     = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_comb begin
    drive_en_c  = (state_d == DRIVE) || (state_d == LOAD);
    load_en_c   = (state_d == LOAD);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == RELEASE);
  end

  onehot_decoder #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_oe_dec (
    .en     (drive_en_c),
    .idx    (src_d),
    .onehot (oe_d)
  );

  onehot_decoder #(
    .N (N_DST),
    .W (DST_W)
  ) u_ld_dec (
    .en     (load_en_c),
    .idx    (dst_d),
    .onehot (ld_d)
  );

  // Async reset drops oe/ld at once so no driver is left on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      oe_q        <= '0;
      ld_q        <= '0;
      last_data_q <= '0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      ld_q        <= ld_d;
      last_data_q <= last_data_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.oe        = oe_q;
  assign bus.ld        = ld_q;
  assign bus.last_data = last_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: directed steps plus a randomized stress run.
// Expected outputs come from a cycles-since-accept timeline model.
module tb_bus_transfer_sequencer;

  localparam int S1 = 1;
  localparam int S5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.N_SRC(4), .N_DST(4), .WIDTH(8)) bif ();
  bus_transfer_sequencer_if #(.N_SRC(3), .N_DST(4), .WIDTH(8)) bif5 ();

  bus_transfer_sequencer #(
    .N_SRC(4), .N_DST(4), .WIDTH(8), .SETTLE_CYCLES(S1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  bus_transfer_sequencer #(
    .N_SRC(3), .N_DST(4), .WIDTH(8), .SETTLE_CYCLES(S5)
  ) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif5)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit inv_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    assert (obs_v === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs_v, exp_v);
    end
  endtask

  // Observed vector: {ready, busy, done, err, oe[3:0], ld[3:0], last_data[7:0]}
  function automatic logic [19:0] obs(input bit use5);
    if (use5)
      return {bif5.req_ready, bif5.busy, bif5.done, bif5.err, 1'b0, bif5.oe, bif5.ld, bif5.last_data};
    return {bif.req_ready, bif.busy, bif.done, bif.err, bif.oe, bif.ld, bif.last_data};
  endfunction

  // k = cycles since the accept cycle (0 = idle); s = settle cycles.
  function automatic logic [19:0] exp_vec(input int k, input int s, input int src, input int dst,
                                          input logic [7:0] last, input logic rdy_ok, input logic err);
    logic [3:0] e_oe;
    logic [3:0] e_ld;
    logic       e_busy;
    logic       e_done;
    logic       e_rdy;
    e_oe   = '0;
    e_ld   = '0;
    e_busy = (k >= 1) && (k <= s + 2);
    e_done = (k == s + 2);
    if ((k >= 1) && (k <= s + 1)) e_oe = 4'(1 << src);
    if (k == s + 1) e_ld = 4'(1 << dst);
    e_rdy = !e_busy && rdy_ok;
    return {e_rdy, e_busy, e_done, err, e_oe, e_ld, last};
  endfunction

  task automatic drive(input bit use5, input logic v, input int src, input int dst, input logic [7:0] d);
    if (use5) begin
      bif5.req_valid = v;
      bif5.req_src   = 2'(src);
      bif5.req_dst   = 2'(dst);
      bif5.bus_in    = d;
    end else begin
      bif.req_valid = v;
      bif.req_src   = 2'(src);
      bif.req_dst   = 2'(dst);
      bif.bus_in    = d;
    end
  endtask

  // Called at a negedge with the target idle and ready; ends idle at a negedge.
  task automatic xfer(input bit use5, input int src, input int dst, input logic [7:0] data,
                      input logic [7:0] prev, input bit hold, input int nsrc, input int ndst,
                      input string tag);
    int s;
    s = use5 ? S5 : S1;
    drive(use5, 1'b1, src, dst, data);
    check({tag, "_acc"}, 32'(obs(use5)), 32'(exp_vec(0, s, src, dst, prev, 1'b1, 1'b0)));
    for (int k = 1; k <= s + 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(use5, hold, hold ? nsrc : src, hold ? ndst : dst, data);
      check($sformatf("%s_k%0d", tag, k), 32'(obs(use5)),
            32'(exp_vec(k, s, src, dst, (k >= s + 2) ? data : prev, 1'b1, 1'b0)));
    end
  endtask

  task automatic reject(input bit use5, input int src, input int dst, input logic [7:0] last,
                        input string tag);
    int s;
    s = use5 ? S5 : S1;
    drive(use5, 1'b1, src, dst, 8'hEE);
    check({tag, "_rdy"}, 32'(obs(use5)), 32'(exp_vec(0, s, 0, 0, last, 1'b1, 1'b0)));
    @(negedge clk);
    drive(use5, 1'b0, src, dst, 8'hEE);
    check({tag, "_err"}, 32'(obs(use5)), 32'(exp_vec(0, s, 0, 0, last, 1'b1, 1'b1)));
    @(negedge clk);
    check({tag, "_clr"}, 32'(obs(use5)), 32'(exp_vec(0, s, 0, 0, last, 1'b1, 1'b0)));
  endtask

  // Bus-safety invariants on both instances, every cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      check("inv_oe_ld", 32'(($countones(bif.oe) <= 1) && ($countones(bif.ld) <= 1) &&
                             ((bif.ld == '0) || (bif.oe != '0))), 32'd1);
      check("inv5_oe_ld", 32'(($countones(bif5.oe) <= 1) && ($countones(bif5.ld) <= 1) &&
                              ((bif5.ld == '0) || (bif5.oe != '0))), 32'd1);
    end
  end

  int         k_m;
  int         m_src;
  int         m_dst;
  logic [7:0] m_last;
  logic       m_err;
  bit         pending;
  int         r_src;
  int         r_dst;
  int         n_hs;
  int         n_acc;
  int         n_done;

  initial begin
    drive(1'b0, 1'b0, 0, 0, 8'h00);
    drive(1'b1, 1'b0, 0, 0, 8'h00);
    #1;
    check("reset_a", 32'(obs(1'b0)), 32'd0);
    check("reset_b", 32'(obs(1'b1)), 32'd0);
    inv_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rel_not_ready", 32'(obs(1'b0)), 32'd0);
    @(negedge clk);
    check("ready_after_rst", 32'(obs(1'b0)), 32'(exp_vec(0, S1, 0, 0, 8'h00, 1'b1, 1'b0)));

    xfer(1'b0, 2, 0, 8'h0A, 8'h00, 1'b0, 0, 0, "basic");
    xfer(1'b0, 1, 3, 8'h3C, 8'h0A, 1'b1, 3, 1, "b2b1");
    xfer(1'b0, 3, 1, 8'h77, 8'h3C, 1'b0, 0, 0, "b2b2");
    reject(1'b0, 2, 2, 8'h77, "rej_same");
    reject(1'b1, 3, 0, 8'h00, "rej_src_range");
    xfer(1'b1, 0, 1, 8'h50, 8'h00, 1'b0, 0, 0, "settle5");

    // Reset asserted between edges while the source is driving.
    drive(1'b0, 1'b1, 3, 0, 8'h99);
    @(posedge clk);
    #2;
    drive(1'b0, 1'b0, 3, 0, 8'h99);
    check("rst_pre_oe", 32'(bif.oe), 32'h8);
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs(1'b0)), 32'd0);
    @(negedge clk);
    check("rst_hold", 32'(obs(1'b0)), 32'd0);
    rst_n = 1'b1;
    check("rst_rel2", 32'(obs(1'b0)), 32'd0);
    @(negedge clk);
    check("rst_ready2", 32'(obs(1'b0)), 32'(exp_vec(0, S1, 0, 0, 8'h00, 1'b1, 1'b0)));
    xfer(1'b0, 1, 2, 8'h1E, 8'h00, 1'b0, 0, 0, "post_rst");

    // Randomized stress against the timeline model.
    k_m = 0; m_src = 0; m_dst = 0; m_last = 8'h1E; m_err = 1'b0;
    pending = 1'b0; r_src = 0; r_dst = 0; n_hs = 0; n_acc = 0; n_done = 0;
    for (int cyc = 0; (cyc < 20000) && ((n_hs < 1000) || (k_m != 0)); cyc++) begin
      check("stress", 32'(obs(1'b0)), 32'(exp_vec(k_m, S1, m_src, m_dst, m_last, 1'b1, m_err)));
      if (bif.done) n_done++;
      if (!pending && (n_hs < 1000) && ($urandom_range(0, 2) == 0)) begin
        pending = 1'b1;
        r_src   = int'($urandom_range(0, 3));
        r_dst   = int'($urandom_range(0, 3));
      end
      drive(1'b0, pending, r_src, r_dst, 8'($urandom));
      m_err = 1'b0;
      if (k_m == S1 + 1) m_last = bif.bus_in;
      if (k_m == 0) begin
        if (pending) begin
          pending = 1'b0;
          n_hs++;
          if (r_src == r_dst) begin
            m_err = 1'b1;
          end else begin
            k_m   = 1;
            m_src = r_src;
            m_dst = r_dst;
            n_acc++;
          end
        end
      end else begin
        k_m = (k_m == S1 + 2) ? 0 : k_m + 1;
      end
      @(negedge clk);
    end
    check("stress_complete", 32'((n_hs == 1000) && (k_m == 0)), 32'd1);
    check("stress_done_count", 32'(n_done), 32'(n_acc));

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
